instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front-end for the RV32I core. Owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction, its PC and its pre-split opcode/funct3/funct7 fields to the control unit. Handles redirects from branch/jump resolution, including discarding a fetch already in flight.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  read request; level, held until ack
- imem_addr  out  XLEN  word address; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  XLEN  redirect target
- stall  in  1  decode cannot accept the held instruction
- inst_valid  out  1  inst/inst_pc/fields valid
- inst  out  32  held instruction
- inst_pc  out  XLEN  PC of inst
- opCode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- fetch_err  out  1  sticky misaligned-redirect flag

## Operation
- States: IDLE, FETCH, DROP, HOLD, HALT. Registers: pc, req_addr, inst, inst_pc, fetch_err.
- IDLE: reset state; no request; next state FETCH.
- FETCH: imem_req=1, imem_addr=req_addr (loaded from pc on entry).
  - ack, no redirect: inst<=imem_rdata, inst_pc<=req_addr, pc<=req_addr+4 (mod 2^XLEN, wraps), go HOLD.
  - ack with redirect: data discarded, pc<=redirect_pc, re-enter FETCH.
  - redirect, no ack: pc<=redirect_pc, go DROP (transaction must complete).
- DROP: imem_req=1 on old req_addr. Further redirects overwrite pc (last wins). On ack: data discarded; go HALT if fetch_err else FETCH.
- HOLD: inst_valid=1. Redirect has priority over stall: instruction discarded, pc<=redirect_pc, go FETCH. Else !stall: consumed, go FETCH. Else stay, all outputs stable.
- Misaligned redirect (redirect_pc[1:0]!=0) in any state: fetch_err<=1; go DROP if a request is outstanding, else HALT. HALT: req=0, valid=0; exit only by reset.
- redirect in IDLE or HALT ignored.
- Fields are combinational slices of the inst register.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0, fetch_err=0, pc=RESET_PC.
- Reset asserted mid-transaction: outstanding request abandoned; memory must tolerate request drop.
- First imem_req one cycle after reset release.
- Ack in cycle N -> inst_valid=1 in N+1.
- Zero-wait memory (ack same cycle as req): peak throughput one instruction per 2 cycles.
- Memory never acks without req; ack during IDLE/HOLD/HALT is ignored.
- imem_addr low two bits always 0.

## Structure
- Shared package (core-wide): fetch state enum, NOP encoding constant, RESET_PC default, opcode constants used by the control unit.
- Single module; no sub-module. PC incrementer and field slicing inline.

## Test plan
- Reset release, zero-wait memory returning 32'h00500093 at 0 -> req at 0x0, inst_valid next cycle, opCode=7'h13, funct3=0, inst_pc=0; next req at 0x4.
- Stall held 3 cycles in HOLD -> inst, inst_pc stable, no imem_req; release -> req at next pc.
- Redirect to 0x100 while memory delays ack 2 cycles -> DROP keeps old addr until ack, data discarded, inst_valid stays 0, next req at 0x100.
- Redirect to 0x40 in HOLD with stall=1 -> inst_valid drops next cycle, req at 0x40.
- Redirect to 0x102 -> fetch_err=1 and stays 1, imem_req=0 after any pending ack, only rst recovers.
- Sequential fetch from 0xFFFF_FFFC -> next req at 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Core-wide definitions shared by the fetch front-end and the control unit:
// fetch FSM encoding, NOP word, reset PC and RV32I major opcodes.
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_DROP  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_HALT  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front-end: owns the PC, runs the imem req/ack handshake and
// holds one fetched instruction for decode, with redirect and in-flight drop.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opCode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            fetch_err
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] pc_inc;
    logic            misaligned;
    logic            redir_ok;

    assign pc_inc     = req_addr + XLEN'(4);
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
    assign redir_ok   = redirect && (redirect_pc[1:0] == 2'b00);

    assign imem_addr = req_addr;
    assign opCode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];

    // imem_req / inst_valid are registered alongside the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FS_IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            inst       <= NOP_INST;
            inst_pc    <= '0;
            fetch_err  <= 1'b0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                FS_IDLE: begin
                    state    <= FS_FETCH;
                    req_addr <= pc;
                    imem_req <= 1'b1;
                end

                FS_FETCH: begin
                    if (misaligned) begin
                        fetch_err <= 1'b1;
                        if (imem_ack) begin
                            state    <= FS_HALT;
                            imem_req <= 1'b0;
                        end else begin
                            state <= FS_DROP;
                        end
                    end else if (redir_ok && imem_ack) begin
                        pc       <= redirect_pc;
                        req_addr <= redirect_pc;
                    end else if (redir_ok) begin
                        pc    <= redirect_pc;
                        state <= FS_DROP;
                    end else if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_pc    <= req_addr;
                        pc         <= pc_inc;
                        state      <= FS_HOLD;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                    end
                end

                // Old request stays on the bus until memory completes it.
                FS_DROP: begin
                    if (misaligned)
                        fetch_err <= 1'b1;
                    else if (redir_ok)
                        pc <= redirect_pc;
                    if (imem_ack) begin
                        if (fetch_err || misaligned) begin
                            state    <= FS_HALT;
                            imem_req <= 1'b0;
                        end else begin
                            state    <= FS_FETCH;
                            req_addr <= redir_ok ? redirect_pc : pc;
                        end
                    end
                end

                FS_HOLD: begin
                    if (misaligned) begin
                        fetch_err  <= 1'b1;
                        state      <= FS_HALT;
                        inst_valid <= 1'b0;
                    end else if (redir_ok) begin
                        pc         <= redirect_pc;
                        req_addr   <= redirect_pc;
                        state      <= FS_FETCH;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                    end else if (!stall) begin
                        req_addr   <= pc;
                        state      <= FS_FETCH;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                    end
                end

                FS_HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end

                default: begin
                    state      <= FS_HALT;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle-stepped stimulus with
// hand-computed expectations for fetch, stall, redirect, wrap and error paths.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .opCode     (opCode),
        .funct3     (funct3),
        .funct7     (funct7),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        step(); step();
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_addr",  imem_addr,           32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst",  inst,                32'h0000_0013);
        chk("rst_ipc",   inst_pc,             32'h0);
        chk("rst_err",   {31'b0, fetch_err},  32'd0);

        // Zero-wait first fetch
        rst = 1'b0;
        step();
        chk("t1_req",  {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr,         32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 1'b0;
        chk("t1_valid", {31'b0, inst_valid}, 32'd1);
        chk("t1_inst",  inst,                32'h0050_0093);
        chk("t1_op",    {25'b0, opCode},     32'h13);
        chk("t1_f3",    {29'b0, funct3},     32'h0);
        chk("t1_ipc",   inst_pc,             32'h0);
        chk("t1_noreq", {31'b0, imem_req},   32'd0);
        step();
        chk("t1_req2",  {31'b0, imem_req},   32'd1);
        chk("t1_addr2", imem_addr,           32'h4);
        chk("t1_vdrop", {31'b0, inst_valid}, 32'd0);

        // Stall held in HOLD
        imem_ack = 1'b1; imem_rdata = 32'h4020_81b3; stall = 1'b1;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_valid", {31'b0, inst_valid}, 32'd1);
            chk("t2_inst",  inst,                32'h4020_81b3);
            chk("t2_ipc",   inst_pc,             32'h4);
            chk("t2_noreq", {31'b0, imem_req},   32'd0);
            step();
        end
        chk("t2_op", {25'b0, opCode}, 32'h33);
        chk("t2_f7", {25'b0, funct7}, 32'h20);
        stall = 1'b0;
        step();
        chk("t2_req",  {31'b0, imem_req}, 32'd1);
        chk("t2_addr", imem_addr,         32'h8);

        // Redirect while ack is delayed: DROP
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("t3_req",   {31'b0, imem_req},   32'd1);
        chk("t3_addr",  imem_addr,           32'h8);
        step();
        chk("t3_addr2", imem_addr,           32'h8);
        chk("t3_valid", {31'b0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
        step();
        imem_ack = 1'b0;
        chk("t3_nvld",  {31'b0, inst_valid}, 32'd0);
        chk("t3_naddr", imem_addr,           32'h100);
        chk("t3_nreq",  {31'b0, imem_req},   32'd1);
        chk("t3_inst",  inst,                32'h4020_81b3);

        // Redirect beats stall in HOLD
        imem_ack = 1'b1; imem_rdata = 32'h0050_f113;
        step();
        imem_ack = 1'b0;
        chk("t4_valid", {31'b0, inst_valid}, 32'd1);
        chk("t4_ipc",   inst_pc,             32'h100);
        chk("t4_f3",    {29'b0, funct3},     32'h7);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("t4_vdrop", {31'b0, inst_valid}, 32'd0);
        chk("t4_req",   {31'b0, imem_req},   32'd1);
        chk("t4_addr",  imem_addr,           32'h40);

        // Ack with redirect re-fetches at target, then wrap past top of memory
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        redirect = 1'b0;
        chk("t5_vld",  {31'b0, inst_valid}, 32'd0);
        chk("t5_addr", imem_addr,           32'hFFFF_FFFC);
        imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        chk("t5_ipc",   inst_pc,             32'hFFFF_FFFC);
        chk("t5_valid", {31'b0, inst_valid}, 32'd1);
        step();
        chk("t5_wrap", imem_addr,         32'h0);
        chk("t5_req",  {31'b0, imem_req}, 32'd1);

        // Misaligned redirect: DROP, then HALT until reset
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        chk("t6_err",  {31'b0, fetch_err}, 32'd1);
        chk("t6_req",  {31'b0, imem_req},  32'd1);
        chk("t6_addr", imem_addr,          32'h0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        imem_ack = 1'b0;
        chk("t6_hreq", {31'b0, imem_req},   32'd0);
        chk("t6_hvld", {31'b0, inst_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        step();
        chk("t6_stay_req", {31'b0, imem_req},  32'd0);
        chk("t6_stay_err", {31'b0, fetch_err}, 32'd1);
        rst = 1'b1;
        step();
        chk("t6_rst_err", {31'b0, fetch_err}, 32'd0);
        rst = 1'b0;
        step();
        chk("t6_rec_req",  {31'b0, imem_req}, 32'd1);
        chk("t6_rec_addr", imem_addr,         32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
